// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranging engine: fires TRIG on a fixed period, synchronises ECHO and
// publishes the echo width in clk cycles, bounded by a timeout.
module hcsr04_ranger #(
    parameter int CNT_W          = 32,
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             echo,
    output logic             trig,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   echo_prev_q, echo_prev_d;
    logic                   arm_q, arm_d;
    logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]       width_cnt_q, width_cnt_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic                   timeout_q, timeout_d;
    logic                   valid_q, valid_d;
    logic                   trig_q, trig_d;
    logic                   busy_q, busy_d;
    logic                   echo_s, rise_s;

    assign echo_s = sync_q[SYNC_STAGES-1];
    assign rise_s = echo_s & ~echo_prev_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], echo};
        echo_prev_d  = echo_s;
        arm_d        = 1'b1;
        period_cnt_d = (period_cnt_q == CNT_MAX) ? period_cnt_q : period_cnt_q + ONE;
        wait_cnt_d   = wait_cnt_q;
        width_cnt_d  = width_cnt_q;
        width_d      = width_q;
        timeout_d    = timeout_q;
        valid_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                period_cnt_d = '0;
                // arm_q holds off the first shot until one clock after reset release
                if (en && arm_q) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (period_cnt_q == TRIG_LAST) begin
                    state_d    = S_WAIT_ECHO;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT_ECHO: begin
                wait_cnt_d = wait_cnt_q + ONE;
                if (rise_s) begin
                    state_d     = S_MEASURE;
                    width_cnt_d = ONE;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_HOLDOFF;
                    width_d   = '0;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!echo_s) begin
                    state_d   = S_HOLDOFF;
                    width_d   = width_cnt_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                end else if (width_cnt_q == TIMEOUT_VAL) begin
                    state_d   = S_HOLDOFF;
                    width_d   = TIMEOUT_VAL;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end else begin
                    width_cnt_d = width_cnt_q + ONE;
                end
            end
            S_HOLDOFF: begin
                // >= keeps the exit reachable even if a long shot overran the period
                if (period_cnt_q >= PERIOD_LAST) state_d = en ? S_TRIG : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_TRIG && state_q != S_TRIG) period_cnt_d = '0;

        trig_d = (state_d == S_TRIG);
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            // NOTE: the synchroniser flops are reset too, so a high ECHO pin
            // during reset cannot fake a rising edge on release.
            sync_q       <= '0;
            echo_prev_q  <= 1'b0;
            arm_q        <= 1'b0;
            period_cnt_q <= '0;
            wait_cnt_q   <= '0;
            width_cnt_q  <= '0;
            width_q      <= '0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            echo_prev_q  <= echo_prev_d;
            arm_q        <= arm_d;
            period_cnt_q <= period_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            width_cnt_q  <= width_cnt_d;
            width_q      <= width_d;
            timeout_q    <= timeout_d;
            valid_q      <= valid_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
        end
    end

    assign trig    = trig_q;
    assign width   = width_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Scoreboard bench for hcsr04_ranger: stimulus queues expected results,
// a negedge monitor pops and compares them whenever valid is seen.
`timescale 1ns/1ps
module tb_hcsr04_ranger;

    localparam int CNT_W          = 16;
    localparam int TRIG_CYCLES    = 4;
    localparam int PERIOD_CYCLES  = 200;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int SYNC_STAGES    = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             en    = 1'b0;
    logic             echo  = 1'b0;
    logic             trig;
    logic [CNT_W-1:0] width;
    logic             valid;
    logic             timeout;
    logic             busy;

    typedef struct {
        int width;
        int timeout;
        int vcyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   trig_rise_q[$];
    int   trig_len  = 0;
    logic trig_prev = 1'b0;
    int   cyc       = 0;
    int   tests     = 0;
    int   fails     = 0;

    hcsr04_ranger #(
        .CNT_W         (CNT_W),
        .TRIG_CYCLES   (TRIG_CYCLES),
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .echo   (echo),
        .trig   (trig),
        .width  (width),
        .valid  (valid),
        .timeout(timeout),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        tests++;
        fails++;
        $display("FAIL %s: waited %0d cycles without the expected event", name, waited);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the cycle index of the edge at which trig dropped.
    task automatic wait_trig_fall(output int f);
        int n = 0;
        while (trig !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        while (trig !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) bound_fail("trig_fall_bound", n);
        f = cyc;
    endtask

    // Monitor: trig pulse length, trig rise times, and scoreboard on valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            trig_prev = 1'b0;
            trig_len  = 0;
        end else begin
            if (trig) begin
                if (!trig_prev) trig_rise_q.push_back(cyc);
                trig_len++;
            end else if (trig_prev) begin
                check("trig_high_cycles", trig_len, TRIG_CYCLES);
                trig_len = 0;
            end
            trig_prev = trig;
            if (valid) begin
                if (sb.size() == 0) begin
                    check("valid_expected", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("valid_width",   32'(width),   mon_e.width);
                    check("valid_timeout", 32'(timeout), mon_e.timeout);
                    check("valid_cycle",   cyc,          mon_e.vcyc);
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int rel;
        int rise;
        int n;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_trig",    32'(trig),    0);
        check("reset_width",   32'(width),   0);
        check("reset_valid",   32'(valid),   0);
        check("reset_timeout", 32'(timeout), 0);
        check("reset_busy",    32'(busy),    0);

        en    = 1'b1;
        rel   = cyc;
        rst_n = 1'b1;

        // Shot 1: nominal 37-cycle echo starting 10 cycles after trig falls.
        wait_trig_fall(f);
        if (trig_rise_q.size() > 0)
            check("first_trig_not_before_2_cycles", 32'(trig_rise_q[0] >= rel + 2), 1);
        tick(10);
        echo = 1'b1;
        tick(37);
        echo = 1'b0;
        sb.push_back('{37, 0, cyc + 3});

        // Shot 2: no echo at all.
        wait_trig_fall(f);
        sb.push_back('{0, 1, f + TIMEOUT_CYCLES});

        // Shot 3: 150-cycle echo saturates at the timeout; then echo goes high
        // again during holdoff so shot 4 starts with a stale level.
        wait_trig_fall(f);
        tick(10);
        echo = 1'b1;
        sb.push_back('{TIMEOUT_CYCLES, 1, cyc + TIMEOUT_CYCLES + 3});
        tick(150);
        echo = 1'b0;
        tick(20);
        echo = 1'b1;

        // Shot 4: echo already high at wait entry and never re-rising.
        wait_trig_fall(f);
        sb.push_back('{0, 1, f + TIMEOUT_CYCLES});

        // Shot 5: stale high ignored until a fresh rising edge of 25 cycles.
        wait_trig_fall(f);
        tick(20);
        echo = 1'b0;
        tick(10);
        echo = 1'b1;
        tick(25);
        echo = 1'b0;
        sb.push_back('{25, 0, cyc + 3});

        // Shot 6: en dropped mid-measure; result still published, then idle.
        wait_trig_fall(f);
        tick(10);
        echo = 1'b1;
        tick(20);
        en = 1'b0;
        check("busy_mid_measure", 32'(busy), 1);
        tick(30);
        echo = 1'b0;
        sb.push_back('{50, 0, cyc + 3});
        tick(f + PERIOD_CYCLES - cyc);
        check("busy_after_holdoff", 32'(busy), 0);
        check("trig_low_in_idle",   32'(trig), 0);
        check("width_held",         32'(width), 50);
        check("trig_count_shots",   trig_rise_q.size(), 6);
        for (int i = 1; i < 6 && i < trig_rise_q.size(); i++)
            check("trig_spacing", trig_rise_q[i] - trig_rise_q[i-1], PERIOD_CYCLES);
        tick(250);
        check("no_trig_after_en_drop", trig_rise_q.size(), 6);

        // Asynchronous reset in the middle of a trig pulse.
        en = 1'b1;
        n  = 0;
        while (trig !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) bound_fail("trig_rise_bound", n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_trig",    32'(trig),    0);
        check("async_rst_valid",   32'(valid),   0);
        check("async_rst_busy",    32'(busy),    0);
        check("async_rst_width",   32'(width),   0);
        check("async_rst_timeout", 32'(timeout), 0);
        repeat (2) @(negedge clk);
        rel   = cyc;
        rst_n = 1'b1;

        // Shot after reset: first trig no earlier than 2 cycles after release.
        wait_trig_fall(f);
        rise = trig_rise_q[trig_rise_q.size() - 1];
        check("trig_after_release_not_before_2", 32'(rise >= rel + 2), 1);
        sb.push_back('{0, 1, f + TIMEOUT_CYCLES});

        n = 0;
        while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) bound_fail("valid_drain_bound", n);
        en = 1'b0;
        tick(5);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hcsr04_ranger.md
# hcsr04_ranger

Self-timed HC-SR04 ranging engine, the parametrised successor of the free-running echo counter. It drives the sensor TRIG pin, synchronises ECHO, and measures echo width in clk cycles. Every measurement is bounded by a timeout and reported through a one-cycle valid strobe. It sits between the sensor pins and the theremin pitch/volume mapping logic.

## Interface
- CNT_W, 32, width of all counters and of `width`; must satisfy TIMEOUT_CYCLES < 2^CNT_W and PERIOD_CYCLES < 2^CNT_W
- TRIG_CYCLES, 500, TRIG high time (10 us at 50 MHz); ≥1
- PERIOD_CYCLES, 3_000_000, minimum spacing between TRIG rising edges (60 ms); must be > TRIG_CYCLES + TIMEOUT_CYCLES + 2
- TIMEOUT_CYCLES, 1_900_000, max wait for echo start and max echo width (38 ms)
- SYNC_STAGES, 2, echo synchroniser depth; ≥2
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  1 = run periodic measurements
- echo  in  1  asynchronous sensor ECHO pin
- trig  out  1  sensor TRIG pin, registered
- width  out  CNT_W  last result in clk cycles, held between strobes
- valid  out  1  one-cycle strobe, new `width`/`timeout` published
- timeout  out  1  qualifies the published result, held with `width`
- busy  out  1  high in every state except IDLE

## Operation
- Reset (rst_n low, any state, takes effect immediately): state IDLE, synchroniser flops 0, all counters 0.
- Outputs during reset: trig=0, width=0, valid=0, timeout=0, busy=0.
- echo_s: `echo` after SYNC_STAGES flops. rise_s = echo_s & ~echo_s_prev.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
- IDLE: if en=1, go to TRIG next cycle; period_cnt cleared.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO. period_cnt runs from 0 in the first TRIG cycle, +1 per cycle, saturating.
- WAIT_ECHO: wait_cnt +1 per cycle.
  - On rise_s, go to MEASURE with width_cnt=1.
  - A level-high echo_s without a rising edge (stuck or late echo from the previous shot) is ignored.
  - If wait_cnt reaches TIMEOUT_CYCLES first: publish width=0, timeout=1, go to HOLDOFF.
- MEASURE: width_cnt +1 each cycle echo_s=1.
  - On echo_s=0: publish width=width_cnt, timeout=0.
  - If width_cnt reaches TIMEOUT_CYCLES while echo_s still 1: publish width=TIMEOUT_CYCLES, timeout=1.
  - Either way, go to HOLDOFF.
- Publish: width and timeout registers load and valid=1 for exactly one cycle, once per TRIG.
- HOLDOFF: stay until period_cnt = PERIOD_CYCLES-1, then TRIG if en=1, else IDLE.
- en is sampled only in IDLE and at HOLDOFF exit. Dropping en mid-measurement completes and publishes the current measurement, then returns to IDLE. Never abort mid-TRIG.
- Counters never wrap; the timeout compare prevents overflow.

## Timing
- TRIG rising edge: registered, one cycle after IDLE sees en=1.
- Successive TRIG rising edges: exactly PERIOD_CYCLES apart while en stays 1.
- width: equals the number of clk cycles echo_s is high, i.e. the pin pulse width ±1 cycle from asynchronous sampling.
- valid latency: valid rises SYNC_STAGES+1 cycles after the falling edge of the echo pin (pin edge meeting setup).
- Echo timeout: valid occurs exactly TIMEOUT_CYCLES cycles after entering WAIT_ECHO.
- Simultaneous rise_s and wait_cnt reaching TIMEOUT_CYCLES: the echo wins, go to MEASURE.
- Echo falling in the same cycle width_cnt reaches TIMEOUT_CYCLES: the normal result wins, width=TIMEOUT_CYCLES, timeout=0.
- rst_n deassertion: first TRIG no earlier than 2 cycles after rst_n rises with en=1.

## Test plan
- Bench parameters for all cases: CNT_W=16, TRIG_CYCLES=4, PERIOD_CYCLES=200, TIMEOUT_CYCLES=100, SYNC_STAGES=2.
- Nominal: en=1; echo high 37 cycles, starting 10 cycles after trig falls -> trig high exactly 4 cycles; one valid, width=37, timeout=0, valid 3 cycles after the echo fall; next trig rise 200 cycles after the first.
- No echo: echo held 0 -> valid 100 cycles after trig falls, width=0, timeout=1; trig repeats at 200-cycle spacing.
- Long echo: echo high 150 cycles -> width=100, timeout=1, exactly one valid; the stale high echo is ignored in the next WAIT_ECHO until a fresh rising edge.
- Echo already high at WAIT_ECHO entry and never re-rising -> width=0, timeout=1.
- en dropped mid-MEASURE (echo 50 cycles) -> width=50 published, no further trig, busy=0 after HOLDOFF; rst_n pulsed low mid-TRIG -> trig, valid, busy, width, timeout all 0 within the same cycle (asynchronous).
